// File: rtl/seven_seg_scan_if.sv
// Bus between a host and the four-digit seven-segment scan controller:
// load/ready capture handshake plus the registered display outputs.
interface seven_seg_scan_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        ready;
  logic [7:0]  led;
  logic [3:0]  ledState;
  logic [7:0]  lights;

  modport master (
    output value,
    output dp_in,
    output load,
    input  ready,
    input  led,
    input  ledState,
    input  lights
  );

  modport slave (
    input  value,
    input  dp_in,
    input  load,
    output ready,
    output led,
    output ledState,
    output lights
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a tear-free,
// frame-boundary value update. Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to
// suppress leading zeros on digits 3..1.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_BLANK | guard interval at slot start, all anodes off
// S_DRIVE | anode of the current digit on, segments decoded
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scan_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [1:0]    dig_q, dig_nxt;
  logic          frame_end;

  logic [15:0]   active_val_q;
  logic [3:0]    active_dp_q;
  logic [15:0]   pend_val_q;
  logic [3:0]    pend_dp_q;
  logic          pend_valid_q;
  logic          ready_q;

  logic [7:0]    led_q, led_nxt;
  logic [3:0]    an_q, an_nxt;
  logic [7:0]    lights_q;

  logic [3:0]    nib;
  logic [3:0]    blank_mask;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot/digit counters and the frame boundary that gates commits.
  always_comb begin
    cnt_nxt   = cnt_q + CW'(1);
    dig_nxt   = dig_q;
    frame_end = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_nxt = '0;
      dig_nxt = dig_q + 2'd1;
      if (dig_q == 2'd3) frame_end = 1'b1;
    end
  end

  // State tracks the counter value it is paired with in the same cycle.
  always_comb begin
    state_nxt = S_BLANK;
    if (cnt_nxt >= CNT_BLANK) state_nxt = S_DRIVE;
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero
  // with no decimal point lit; digit 0 is never suppressed.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = (active_val_q[15:12] == 4'h0) && !active_dp_q[3];
    blank_mask[2] = blank_mask[3] && (active_val_q[11:8] == 4'h0) && !active_dp_q[2];
    blank_mask[1] = blank_mask[2] && (active_val_q[7:4] == 4'h0) && !active_dp_q[1];
  end
`else
  assign blank_mask = 4'b0000;
`endif

  assign nib = active_val_q[{dig_q, 2'b00} +: 4];

  always_comb begin
    led_nxt = 8'hFF;
    an_nxt  = 4'hF;
    if (state_q == S_DRIVE) begin
      an_nxt = ~(4'b0001 << dig_q);
      if (!blank_mask[dig_q]) begin
        led_nxt = {~active_dp_q[dig_q], hex7(nib)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      dig_q   <= dig_nxt;
    end
  end

  // Capture/commit path; reset wins over both load and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_val_q <= 16'h0000;
      active_dp_q  <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      lights_q     <= 8'h00;
    end else if (frame_end && pend_valid_q) begin
      active_val_q <= pend_val_q;
      active_dp_q  <= pend_dp_q;
      lights_q     <= pend_val_q[7:0];
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (bus.load && ready_q) begin
      pend_val_q   <= bus.value;
      pend_dp_q    <= bus.dp_in;
      pend_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 8'hFF;
      an_q  <= 4'hF;
    end else begin
      led_q <= led_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.led      = led_q;
  assign bus.ledState = an_q;
  assign bus.lights   = lights_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with an 8-cycle slot, 2-cycle guard
// (32-cycle frame); expectations follow SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  seven_seg_scan_if ifc ();

  seven_seg_scan_ctrl #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     v;
    logic [3:0]      dp;
    logic [3:0][7:0] led;
    logic [7:0]      lights;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [7:0] idle_led(input int slot);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    return (slot == 0) ? 8'hC0 : 8'hFF;
`else
    return 8'hC0;
`endif
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_led"},      {8'h0, ifc.led},      16'h00FF);
    chk({tag, "_ledState"}, {12'h0, ifc.ledState}, 16'h000F);
    chk({tag, "_lights"},   {8'h0, ifc.lights},   16'h0000);
    chk({tag, "_ready"},    {15'h0, ifc.ready},   16'h0001);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    k = 0;
    chk_reset_vals("rst_during");
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ifc.ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (ifc.ready !== 1'b1) chk("ready_timeout", {15'h0, ifc.ready}, 16'h0001);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    wait_ready();
    ifc.value = v;
    ifc.dp_in = dp;
    ifc.load  = 1'b1;
    tick();
    ifc.load = 1'b0;
    chk("ready_low_after_load", {15'h0, ifc.ready}, 16'h0000);
  endtask

  // base is the k at which ready rose (commit edge); the next frame starts there.
  task automatic check_digits(input string tag, input logic [3:0][7:0] exp, input int base);
    for (int d = 0; d < 4; d++) begin
      run_to(base + d * 8 + 3);
      chk({tag, "_led"},      {8'h0, ifc.led},       {8'h0, exp[d]});
      chk({tag, "_ledState"}, {12'h0, ifc.ledState}, {12'h0, ~(4'b0001 << d)});
    end
  endtask

  initial begin
    int base;
    ifc.value = 16'h0;
    ifc.dp_in = 4'h0;
    ifc.load  = 1'b0;

    vecs[0] = '{16'h1234, 4'b0001, {8'hF9, 8'hA4, 8'hB0, 8'h19}, 8'h34};
    vecs[1] = '{16'hFFFF, 4'b1111, {8'h0E, 8'h0E, 8'h0E, 8'h0E}, 8'hFF};
    vecs[2] = '{16'hA5C0, 4'b1010, {8'h08, 8'h92, 8'h46, 8'hC0}, 8'hC0};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'h0005, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h92}, 8'h05};
    vecs[4] = '{16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 8'h00};
    vecs[5] = '{16'h0070, 4'b0100, {8'hFF, 8'h40, 8'hF8, 8'hC0}, 8'h70};
`else
    vecs[3] = '{16'h0005, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'h92}, 8'h05};
    vecs[4] = '{16'h0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 8'h00};
    vecs[5] = '{16'h0070, 4'b0100, {8'hC0, 8'h40, 8'hF8, 8'hC0}, 8'h70};
`endif

    // Idle scan after reset: outputs after edge k reflect frame position k-1.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      int p, slot, c;
      tick();
      p    = k - 1;
      slot = (p / 8) % 4;
      c    = p % 8;
      if (c < 2) begin
        chk("idle_blank_led", {8'h0, ifc.led},       16'h00FF);
        chk("idle_blank_an",  {12'h0, ifc.ledState}, 16'h000F);
      end else begin
        chk("idle_drive_led", {8'h0, ifc.led},       {8'h0, idle_led(slot)});
        chk("idle_drive_an",  {12'h0, ifc.ledState}, {12'h0, ~(4'b0001 << slot)});
      end
      chk("idle_lights", {8'h0, ifc.lights}, 16'h0000);
      chk("idle_ready",  {15'h0, ifc.ready}, 16'h0001);
    end

    // Load 1234 on edge 5, ignored second load, no tearing, commit at edge 32.
    do_reset();
    run_to(4);
    ifc.value = 16'h1234; ifc.dp_in = 4'b0001; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    chk("hs_ready_low", {15'h0, ifc.ready}, 16'h0000);
    run_to(10);
    ifc.value = 16'hFFFF; ifc.dp_in = 4'hF; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    chk("hs_ignored_ready", {15'h0, ifc.ready}, 16'h0000);
    run_to(27);
    chk("hs_no_tear_led", {8'h0, ifc.led},       {8'h0, idle_led(3)});
    chk("hs_no_tear_an",  {12'h0, ifc.ledState}, 16'h0007);
    run_to(31);
    chk("hs_ready_before_commit", {15'h0, ifc.ready}, 16'h0000);
    chk("hs_lights_before_commit", {8'h0, ifc.lights}, 16'h0000);
    tick();
    chk("hs_ready_after_commit", {15'h0, ifc.ready}, 16'h0001);
    chk("hs_lights_after_commit", {8'h0, ifc.lights}, 16'h0034);
    check_digits("hs_1234", vecs[0].led, 32);

    // Load on the commit edge is dropped; load on the following edge is taken.
    do_load(16'h0005, 4'b0000);
    base = ((k / 32) + 1) * 32;
    run_to(base - 1);
    ifc.value = 16'h0070; ifc.dp_in = 4'b0100; ifc.load = 1'b1;
    tick();
    chk("commit_edge_ready", {15'h0, ifc.ready}, 16'h0001);
    chk("commit_edge_lights", {8'h0, ifc.lights}, 16'h0005);
    tick();
    ifc.load = 1'b0;
    chk("post_commit_load_ready", {15'h0, ifc.ready}, 16'h0000);
    wait_ready();
    chk("post_commit_lights", {8'h0, ifc.lights}, 16'h0070);
    check_digits("post_commit", vecs[5].led, k);

    // Reset pulse while a value is pending discards both active and pending.
    do_load(16'hBEEF, 4'hF);
    do_reset();
    tick();
    chk_reset_vals("rst_after");
    run_to(3);
    chk("rst_lost_active_led", {8'h0, ifc.led},       16'h00C0);
    chk("rst_lost_active_an",  {12'h0, ifc.ledState}, 16'h000E);
    run_to(35);
    chk("rst_lost_pend_led",    {8'h0, ifc.led},    16'h00C0);
    chk("rst_lost_pend_lights", {8'h0, ifc.lights}, 16'h0000);
    chk("rst_lost_pend_ready",  {15'h0, ifc.ready}, 16'h0001);

    // Table of values: commit each and check every digit of the next frame.
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].v, vecs[i].dp);
      wait_ready();
      chk("vec_lights", {8'h0, ifc.lights}, {8'h0, vecs[i].lights});
      check_digits("vec", vecs[i].led, k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
